// File: rtl/pipeline_hazard_ctrl.sv
// Decode-stage hazard controller for the 5-stage SPARC pipeline.
// Stalls the front end on load-use hazards and inserts a bubble via ctrl_nop.
// Also produces the operand-forwarding selects and the annul flush of the delay slot.
// Optional performance counters are built only when HAZ_PERF_CNT_EN is defined;
// without it, stall_cnt/annul_cnt are tied to zero and no counter flops exist.
module pipeline_hazard_ctrl #(
    parameter int REG_AW            = 5,
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int CNT_W             = 16
) (
    input  logic              Clk,
    input  logic              R,
    input  logic [REG_AW-1:0] ID_rs1,
    input  logic [REG_AW-1:0] ID_rs2,
    input  logic              ID_use_rs1,
    input  logic              ID_use_rs2,
    input  logic              ID_B_instr,
    input  logic              ID_29_a,
    input  logic              ID_br_always,
    input  logic              ID_br_taken,
    input  logic [REG_AW-1:0] EX_rd,
    input  logic [REG_AW-1:0] MEM_rd,
    input  logic [REG_AW-1:0] WB_rd,
    input  logic              EX_RF_enable,
    input  logic              MEM_RF_enable,
    input  logic              WB_RF_enable,
    input  logic              EX_load_instr,
    output logic              PC_LE,
    output logic              nPC_LE,
    output logic              IF_ID_LE,
    output logic              IF_ID_flush,
    output logic              ctrl_nop,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  annul_cnt
);

    // state | meaning
    // RUN   | normal issue; a load-use hazard stalls in the same cycle
    // STALL | extra bubble cycles while the load result is still in flight
    typedef enum logic {RUN, STALL} state_t;

    // The first bubble is issued from RUN, so STALL only covers the remaining ones.
    localparam logic [2:0] STALL_INIT = 3'(LOAD_STALL_CYCLES - 1);

    state_t     state, state_next;
    logic [2:0] cnt, cnt_next;
    logic       hazard;
    logic       annul;
    logic       stall;
    logic [1:0] sel_a, sel_b;

    // Load-use detection against the instruction currently in EX; r0 never hazards.
    always_comb begin
        hazard = EX_load_instr & EX_RF_enable & (EX_rd != '0) &
                 ((ID_use_rs1 & (ID_rs1 == EX_rd)) | (ID_use_rs2 & (ID_rs2 == EX_rd)));
        annul  = ID_B_instr & ID_29_a & (ID_br_always | ~ID_br_taken);
    end

    // Operand source priority: youngest producer first, loads in EX excluded.
    function automatic logic [1:0] fwd_pick(
        input logic              rd_use,
        input logic [REG_AW-1:0] rs,
        input logic [REG_AW-1:0] ex_rd,
        input logic              ex_fwd_ok,
        input logic [REG_AW-1:0] mem_rd,
        input logic              mem_en,
        input logic [REG_AW-1:0] wb_rd,
        input logic              wb_en
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (rd_use && (rs != '0)) begin
            if (ex_fwd_ok && (rs == ex_rd))
                sel = 2'b01;
            else if (mem_en && (rs == mem_rd))
                sel = 2'b10;
            else if (wb_en && (rs == wb_rd))
                sel = 2'b11;
        end
        return sel;
    endfunction

    // Forwarding selects are purely combinational and independent of the FSM.
    always_comb begin
        sel_a = fwd_pick(ID_use_rs1, ID_rs1, EX_rd, EX_RF_enable & ~EX_load_instr,
                         MEM_rd, MEM_RF_enable, WB_rd, WB_RF_enable);
        sel_b = fwd_pick(ID_use_rs2, ID_rs2, EX_rd, EX_RF_enable & ~EX_load_instr,
                         MEM_rd, MEM_RF_enable, WB_rd, WB_RF_enable);
    end

    // State and bubble counter; reset aborts any stall in progress.
    always_ff @(posedge Clk or negedge R) begin
        if (!R) begin
            state <= RUN;
            cnt   <= 3'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Next-state logic and output decode; outputs are forced while reset is held.
    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        stall       = 1'b0;
        PC_LE       = 1'b1;
        nPC_LE      = 1'b1;
        IF_ID_LE    = 1'b1;
        ctrl_nop    = 1'b1;
        IF_ID_flush = 1'b0;
        fwd_a       = 2'b00;
        fwd_b       = 2'b00;

        case (state)
            RUN: begin
                if (hazard) begin
                    stall = 1'b1;
                    if (LOAD_STALL_CYCLES > 1) begin
                        state_next = STALL;
                        cnt_next   = STALL_INIT;
                    end
                end
            end
            STALL: begin
                stall    = 1'b1;
                cnt_next = cnt - 3'd1;
                if (cnt <= 3'd1)
                    state_next = RUN;
            end
            default: state_next = RUN;
        endcase

        if (R) begin
            PC_LE       = ~stall;
            nPC_LE      = ~stall;
            IF_ID_LE    = ~stall;
            ctrl_nop    = stall;
            // A stalled branch is re-evaluated afterwards, so it must not annul now.
            IF_ID_flush = annul & ~stall;
            fwd_a       = sel_a;
            fwd_b       = sel_b;
        end
    end

`ifdef HAZ_PERF_CNT_EN
    logic [CNT_W-1:0] stall_q, annul_q;

    // Saturating event counters for stall and annul cycles.
    always_ff @(posedge Clk or negedge R) begin
        if (!R) begin
            stall_q <= '0;
            annul_q <= '0;
        end else begin
            if (stall && (stall_q != '1))
                stall_q <= stall_q + 1'b1;
            if (IF_ID_flush && (annul_q != '1))
                annul_q <= annul_q + 1'b1;
        end
    end

    assign stall_cnt = stall_q;
    assign annul_cnt = annul_q;
`else
    assign stall_cnt = '0;
    assign annul_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: one instance with a single-cycle
// load latency (u1) and one with three bubble cycles (u3). Each has its own
// EX load flag so a hazard can be raised on one without disturbing the other.
module tb_pipeline_hazard_ctrl;

    localparam int AW = 5;
    localparam int CW = 16;

    logic          Clk = 1'b0;
    logic          R;
    logic [AW-1:0] ID_rs1, ID_rs2, EX_rd, MEM_rd, WB_rd;
    logic          ID_use_rs1, ID_use_rs2, ID_B_instr, ID_29_a, ID_br_always, ID_br_taken;
    logic          EX_RF_enable, MEM_RF_enable, WB_RF_enable;
    logic          ld_1, ld_3;

    logic          pc_1, npc_1, ifid_1, flush_1, nop_1;
    logic [1:0]    fa_1, fb_1;
    logic [CW-1:0] scnt_1, acnt_1;
    logic          pc_3, npc_3, ifid_3, flush_3, nop_3;
    logic [1:0]    fa_3, fb_3;
    logic [CW-1:0] scnt_3, acnt_3;

    int total = 0;
    int passed = 0;

    pipeline_hazard_ctrl #(.REG_AW(AW), .LOAD_STALL_CYCLES(1), .CNT_W(CW)) u1 (
        .Clk(Clk), .R(R), .ID_rs1(ID_rs1), .ID_rs2(ID_rs2),
        .ID_use_rs1(ID_use_rs1), .ID_use_rs2(ID_use_rs2), .ID_B_instr(ID_B_instr),
        .ID_29_a(ID_29_a), .ID_br_always(ID_br_always), .ID_br_taken(ID_br_taken),
        .EX_rd(EX_rd), .MEM_rd(MEM_rd), .WB_rd(WB_rd), .EX_RF_enable(EX_RF_enable),
        .MEM_RF_enable(MEM_RF_enable), .WB_RF_enable(WB_RF_enable), .EX_load_instr(ld_1),
        .PC_LE(pc_1), .nPC_LE(npc_1), .IF_ID_LE(ifid_1), .IF_ID_flush(flush_1),
        .ctrl_nop(nop_1), .fwd_a(fa_1), .fwd_b(fb_1), .stall_cnt(scnt_1), .annul_cnt(acnt_1));

    pipeline_hazard_ctrl #(.REG_AW(AW), .LOAD_STALL_CYCLES(3), .CNT_W(CW)) u3 (
        .Clk(Clk), .R(R), .ID_rs1(ID_rs1), .ID_rs2(ID_rs2),
        .ID_use_rs1(ID_use_rs1), .ID_use_rs2(ID_use_rs2), .ID_B_instr(ID_B_instr),
        .ID_29_a(ID_29_a), .ID_br_always(ID_br_always), .ID_br_taken(ID_br_taken),
        .EX_rd(EX_rd), .MEM_rd(MEM_rd), .WB_rd(WB_rd), .EX_RF_enable(EX_RF_enable),
        .MEM_RF_enable(MEM_RF_enable), .WB_RF_enable(WB_RF_enable), .EX_load_instr(ld_3),
        .PC_LE(pc_3), .nPC_LE(npc_3), .IF_ID_LE(ifid_3), .IF_ID_flush(flush_3),
        .ctrl_nop(nop_3), .fwd_a(fa_3), .fwd_b(fb_3), .stall_cnt(scnt_3), .annul_cnt(acnt_3));

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic idle();
        ID_rs1 = '0; ID_rs2 = '0; EX_rd = '0; MEM_rd = '0; WB_rd = '0;
        ID_use_rs1 = 0; ID_use_rs2 = 0; ID_B_instr = 0; ID_29_a = 0;
        ID_br_always = 0; ID_br_taken = 0;
        EX_RF_enable = 0; MEM_RF_enable = 0; WB_RF_enable = 0;
        ld_1 = 0; ld_3 = 0;
    endtask

    // Advance to the next falling edge; new inputs are applied there and checked 1 ns later.
    task automatic cyc();
        @(negedge Clk);
    endtask

    // Packs {PC_LE, nPC_LE, IF_ID_LE, ctrl_nop, IF_ID_flush} for compact checks.
    function automatic logic [4:0] o1();
        return {pc_1, npc_1, ifid_1, nop_1, flush_1};
    endfunction
    function automatic logic [4:0] o3();
        return {pc_3, npc_3, ifid_3, nop_3, flush_3};
    endfunction

    int exp_s3, exp_a1;

    initial begin
`ifdef HAZ_PERF_CNT_EN
        exp_s3 = 3;
        exp_a1 = 3;
`else
        exp_s3 = 0;
        exp_a1 = 0;
`endif
        // 1: reset forcing, even with an annulling branch and hazard present
        R = 1'b0;
        idle();
        ID_B_instr = 1; ID_29_a = 1;
        ld_1 = 1; EX_RF_enable = 1; EX_rd = 5'd5; ID_use_rs1 = 1; ID_rs1 = 5'd5;
        #1;
        chk("rst_out_u1", 32'(o1()), 32'b11110);
        chk("rst_fwd_u1", 32'({fa_1, fb_1}), 32'h0);
        chk("rst_cnt_u1", 32'(scnt_1), 32'h0);
        cyc(); idle(); R = 1'b1; #1;
        chk("run_idle_u1", 32'(o1()), 32'b11100);
        chk("run_idle_u3", 32'(o3()), 32'b11100);

        // 2: single-cycle load-use stall, then MEM forwarding
        cyc();
        ld_1 = 1; EX_RF_enable = 1; EX_rd = 5'd5; ID_use_rs1 = 1; ID_rs1 = 5'd5; #1;
        chk("ls1_stall", 32'(o1()), 32'b00010);
        chk("ls1_fwd_ex_load", 32'(fa_1), 32'h0);
        chk("ls1_u3_unaffected", 32'(o3()), 32'b11100);
        cyc();
        ld_1 = 0; EX_RF_enable = 0; EX_rd = '0; MEM_rd = 5'd5; MEM_RF_enable = 1; #1;
        chk("ls1_release", 32'(o1()), 32'b11100);
        chk("ls1_fwd_mem", 32'(fa_1), 32'b10);

        // 3: three-cycle stall on u3; flush suppressed inside STALL
        cyc(); idle();
        ld_3 = 1; EX_RF_enable = 1; EX_rd = 5'd5; ID_use_rs1 = 1; ID_rs1 = 5'd5; #1;
        chk("ls3_c0", 32'(o3()), 32'b00010);
        cyc();
        ID_B_instr = 1; ID_29_a = 1; #1;
        chk("ls3_c1", 32'(o3()), 32'b00010);
        chk("ls3_u1_annul", 32'(flush_1), 32'h1);
        cyc();
        ID_B_instr = 0; ID_29_a = 0; ld_3 = 0; #1;
        chk("ls3_c2_ignores_hazard", 32'(o3()), 32'b00010);
        cyc(); idle(); #1;
        chk("ls3_c3_run", 32'(o3()), 32'b11100);
        chk("ls3_stall_cnt", 32'(scnt_3), 32'(exp_s3));

        // 4: annul decode on u1
        cyc(); idle(); ID_B_instr = 1; ID_29_a = 1; ID_br_taken = 0; #1;
        chk("bne_a_untaken", 32'(flush_1), 32'h1);
        cyc(); ID_br_taken = 1; #1;
        chk("bne_a_taken", 32'(flush_1), 32'h0);
        cyc(); ID_br_always = 1; #1;
        chk("ba_a", 32'(flush_1), 32'h1);
        cyc(); ID_29_a = 0; #1;
        chk("ba_no_a", 32'(flush_1), 32'h0);
        cyc(); ID_29_a = 1; ID_br_always = 0; ID_br_taken = 0;
        ld_1 = 1; EX_RF_enable = 1; EX_rd = 5'd9; ID_use_rs2 = 1; ID_rs2 = 5'd9; #1;
        chk("stall_beats_annul", 32'(o1()), 32'b00010);
        cyc(); idle(); #1;
        chk("annul_cnt_u1", 32'(acnt_1), 32'(exp_a1));

        // 5: forwarding priority and r0
        cyc(); idle();
        EX_rd = 5'd7; EX_RF_enable = 1; MEM_rd = 5'd7; MEM_RF_enable = 1;
        ID_use_rs2 = 1; ID_rs2 = 5'd7; #1;
        chk("fwd_b_ex_prio", 32'(fb_1), 32'b01);
        chk("fwd_b_no_stall", 32'(o1()), 32'b11100);
        cyc(); ld_1 = 1; #1;
        chk("fwd_b_skip_ex_load", 32'(fb_1), 32'b10);
        cyc(); idle();
        WB_rd = 5'd3; WB_RF_enable = 1; MEM_rd = 5'd4; MEM_RF_enable = 1;
        ID_use_rs1 = 1; ID_rs1 = 5'd3; ID_use_rs2 = 0; ID_rs2 = 5'd4; #1;
        chk("fwd_wb_and_unused", 32'({fa_1, fb_1}), 32'b1100);
        cyc(); idle();
        EX_RF_enable = 1; MEM_RF_enable = 1; WB_RF_enable = 1; ld_1 = 1;
        ID_use_rs1 = 1; ID_use_rs2 = 1; #1;
        chk("r0_fwd", 32'({fa_1, fb_1}), 32'h0);
        chk("r0_no_stall", 32'(o1()), 32'b11100);

        // 6: reset in the middle of a stall on u3
        cyc(); idle();
        ld_3 = 1; EX_RF_enable = 1; EX_rd = 5'd6; ID_use_rs2 = 1; ID_rs2 = 5'd6; #1;
        chk("abort_enter", 32'(o3()), 32'b00010);
        cyc(); idle(); R = 1'b0; #1;
        chk("abort_forced", 32'(o3()), 32'b11110);
        chk("abort_cnt_clr", 32'(scnt_3), 32'h0);
        cyc(); R = 1'b1; #1;
        chk("abort_run", 32'(o3()), 32'b11100);
        cyc(); #1;
        chk("abort_no_residual", 32'(o3()), 32'b11100);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
